// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, frame geometry and parity-mode encoding.
// Used by uart_tx, the controller and the receiver.
package uart_pkg;

  localparam int UART_DATA_BITS       = 8;
  localparam int UART_START_BITS      = 1;
  localparam int UART_MIN_STOP_BITS   = 1;
  localparam int UART_BASE_FRAME_BITS = UART_START_BITS + UART_DATA_BITS + UART_MIN_STOP_BITS;
  localparam int UART_MAX_FRAME_BITS  = UART_BASE_FRAME_BITS + 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP   = 3'd5
  } uart_state_e;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_mode_e;

  function automatic parity_mode_e parity_mode(input logic en, input logic odd);
    if (!en) return PAR_NONE;
    return odd ? PAR_ODD : PAR_EVEN;
  endfunction

  // Bits per frame including start, parity and stop bits.
  function automatic int frame_bits(input parity_mode_e mode, input logic two_stop);
    return UART_BASE_FRAME_BITS + int'(mode != PAR_NONE) + int'(two_stop);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-time generator: counts 0..div and pulses bit_tick on the terminal count.
// clear holds the count at zero so the first bit after release is full length.
module uart_baud_gen #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 bit_tick
);

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;

  assign bit_tick = (cnt_q == div);

  always_comb begin
    cnt_d = cnt_q + DIV_WIDTH'(1);
    if (clear || bit_tick) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: pops the TX FIFO from IDLE, serializes start/8 data/parity/stop on txd (registered).
// txd falls two cycles after the pop; no pop while busy, disabled or the FIFO is empty.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DIV_WIDTH-1:0]  baud_div,
  input  logic                  parity_en,
  input  logic                  parity_odd,
  input  logic                  two_stop,
  input  logic                  tx_enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  output logic                  txd,
  output logic                  tx_busy,
  output logic                  frame_done
);

  uart_state_e state_q, state_d;

  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      par_acc_q, par_acc_d;
  logic [2:0]                bit_cnt_q, bit_cnt_d;
  logic                      stop_cnt_q, stop_cnt_d;
  logic [DIV_WIDTH-1:0]      div_q, div_d;
  parity_mode_e              mode_q, mode_d;
  logic                      two_stop_q, two_stop_d;
  logic                      txd_q, txd_d;
  logic                      frame_done_q, frame_done_d;
  logic                      bit_tick;
  logic                      pop_req;
  logic                      unused_hi_bits;

  assign unused_hi_bits = ^fifo_rd_data[DATA_WIDTH-1:UART_DATA_BITS];

  uart_baud_gen #(.DIV_WIDTH(DIV_WIDTH)) u_baud (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    ((state_q == ST_IDLE) || (state_q == ST_FETCH)),
    .div      (div_q),
    .bit_tick (bit_tick)
  );

  assign pop_req = (state_q == ST_IDLE) && tx_enable && !fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (pop_req) state_d = ST_FETCH;
      ST_FETCH:  state_d = ST_START;
      ST_START:  if (bit_tick) state_d = ST_DATA;
      ST_DATA:   if (bit_tick && (bit_cnt_q == 3'd7))
                   state_d = (mode_q != PAR_NONE) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (bit_tick) state_d = ST_STOP;
      ST_STOP:   if (bit_tick && (!two_stop_q || stop_cnt_q)) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Frame format is captured once per word so config writes never corrupt a frame in flight.
  always_comb begin
    shift_d    = shift_q;
    par_acc_d  = par_acc_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    div_d      = div_q;
    mode_d     = mode_q;
    two_stop_d = two_stop_q;
    if (state_q == ST_FETCH) begin
      shift_d    = fifo_rd_data[UART_DATA_BITS-1:0];
      par_acc_d  = 1'b0;
      bit_cnt_d  = 3'd0;
      stop_cnt_d = 1'b0;
      div_d      = baud_div;
      mode_d     = parity_mode(parity_en, parity_odd);
      two_stop_d = two_stop;
    end
    if ((state_q == ST_DATA) && bit_tick) begin
      shift_d   = {1'b0, shift_q[UART_DATA_BITS-1:1]};
      par_acc_d = par_acc_q ^ shift_q[0];
      bit_cnt_d = bit_cnt_q + 3'd1;
    end
    if ((state_q == ST_STOP) && bit_tick) stop_cnt_d = two_stop_q && !stop_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q    <= '0;
      par_acc_q  <= 1'b0;
      bit_cnt_q  <= 3'd0;
      stop_cnt_q <= 1'b0;
      div_q      <= '0;
      mode_q     <= PAR_NONE;
      two_stop_q <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      par_acc_q  <= par_acc_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      div_q      <= div_d;
      mode_q     <= mode_d;
      two_stop_q <= two_stop_d;
    end
  end

  // txd is decoded from the next state so the registered line lines up with the state.
  always_comb begin
    txd_d = 1'b1;
    unique case (state_d)
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = shift_d[0];
      ST_PARITY: txd_d = par_acc_d ^ (mode_q == PAR_ODD);
      default:   txd_d = 1'b1;
    endcase
    frame_done_d = (state_q == ST_STOP) && (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txd_q        <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      txd_q        <= txd_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign fifo_rd_en = pop_req && rst_n;
  assign txd        = txd_q;
  assign tx_busy    = (state_q != ST_IDLE);
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: a small FIFO model feeds words, txd is captured per cycle on the falling edge.
module tb_uart_tx;

  localparam int DW = 16;
  localparam int VW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [VW-1:0] baud_div;
  logic          parity_en, parity_odd, two_stop, tx_enable;
  logic          fifo_empty;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          fifo_rd_en, txd, tx_busy, frame_done;

  always #5 clk = ~clk;

  uart_tx #(.DATA_WIDTH(DW), .DIV_WIDTH(VW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .baud_div     (baud_div),
    .parity_en    (parity_en),
    .parity_odd   (parity_odd),
    .two_stop     (two_stop),
    .tx_enable    (tx_enable),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_en   (fifo_rd_en),
    .txd          (txd),
    .tx_busy      (tx_busy),
    .frame_done   (frame_done)
  );

  int n_cmp = 0;
  int n_err = 0;

  // FIFO model: read data appears the cycle after the pop strobe.
  logic [DW-1:0] mem [0:15];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int cyc = 0;
  int bad_pop = 0;
  int pop_times[$];

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd_en) begin
      if (wr_ptr == rd_ptr) bad_pop <= bad_pop + 1;
      fifo_rd_data <= mem[rd_ptr % 16];
      rd_ptr <= rd_ptr + 1;
      pop_times.push_back(cyc);
    end
  end

  task automatic push(input logic [DW-1:0] w);
    mem[wr_ptr % 16] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  logic cap_txd  [0:63];
  logic cap_fd   [0:63];

  task automatic wait_start(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (txd === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Offset 0 is the current falling edge.
  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      cap_txd[i] = txd;
      cap_fd[i]  = frame_done;
    end
  endtask

  function automatic logic [11:0] frame_obs(input int nbits, input int b, input bit last);
    logic [11:0] v;
    v = '0;
    for (int k = 0; k < nbits; k++) v[k] = cap_txd[k*b + (last ? b-1 : 0)];
    return v;
  endfunction

  function automatic int fd_index(input int n);
    for (int i = 0; i < n; i++) if (cap_fd[i] === 1'b1) return i;
    return -1;
  endfunction

  function automatic int fd_count(input int n);
    int c;
    c = 0;
    for (int i = 0; i < n; i++) if (cap_fd[i] === 1'b1) c++;
    return c;
  endfunction

  task automatic test_reset();
    baud_div = 16'd3; parity_en = 0; parity_odd = 0; two_stop = 0; tx_enable = 1'b1;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    push(16'hA555);
    repeat (5) begin
      @(negedge clk);
      n_cmp++;
      if ({txd, fifo_rd_en, tx_busy, frame_done} !== 4'b1000) begin
        n_err++;
        $display("FAIL reset_outputs: txd/rd_en/busy/done got %b want 1000",
                 {txd, fifo_rd_en, tx_busy, frame_done});
      end
    end
  endtask

  task automatic test_basic();
    int lat;
    logic fetch_txd;
    logic [11:0] v;
    int base;
    base = pop_times.size();
    lat = -1;
    fetch_txd = 1'bx;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    if (fifo_rd_en === 1'b1) begin
      for (int k = 1; k <= 6; k++) begin
        @(negedge clk);
        if (k == 1) fetch_txd = txd;
        if (txd === 1'b0) begin
          lat = k;
          break;
        end
      end
    end
    n_cmp++;
    if (lat != 2) begin n_err++; $display("FAIL basic_latency: pop-to-start %0d cycles want 2", lat); end
    n_cmp++;
    if (fetch_txd !== 1'b1) begin n_err++; $display("FAIL basic_fetch_idle: txd %b want 1", fetch_txd); end
    capture(43);
    v = frame_obs(10, 4, 1'b0);
    n_cmp++;
    if (v !== 12'h2AA) begin n_err++; $display("FAIL basic_bits_first: got %h want 2aa", v); end
    v = frame_obs(10, 4, 1'b1);
    n_cmp++;
    if (v !== 12'h2AA) begin n_err++; $display("FAIL basic_bits_last: got %h want 2aa", v); end
    n_cmp++;
    if (fd_index(43) != 40) begin n_err++; $display("FAIL basic_done_pos: got %0d want 40", fd_index(43)); end
    n_cmp++;
    if (fd_count(43) != 1) begin n_err++; $display("FAIL basic_done_width: got %0d want 1", fd_count(43)); end
    n_cmp++;
    if (pop_times.size() - base != 1) begin
      n_err++; $display("FAIL basic_pops: got %0d want 1", pop_times.size() - base);
    end
    tx_enable = 1'b0;
  endtask

  typedef struct {
    logic        odd;
    logic        two;
    logic [11:0] vec;
    int          nbits;
  } par_vec_t;

  task automatic test_parity();
    par_vec_t tbl [2];
    bit ok;
    int flen;
    logic [11:0] v;
    tbl[0] = '{odd: 1'b0, two: 1'b0, vec: 12'h60E, nbits: 11};
    tbl[1] = '{odd: 1'b1, two: 1'b1, vec: 12'hC0E, nbits: 12};
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      baud_div = 16'd3; parity_en = 1'b1; parity_odd = tbl[t].odd; two_stop = tbl[t].two;
      push(16'hFF07);
      tx_enable = 1'b1;
      wait_start(20, ok);
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL parity%0d_start: no start bit seen", t); end
      flen = 4 * tbl[t].nbits;
      capture(flen + 3);
      tx_enable = 1'b0;
      v = frame_obs(tbl[t].nbits, 4, 1'b0);
      n_cmp++;
      if (v !== tbl[t].vec) begin n_err++; $display("FAIL parity%0d_bits_first: got %h want %h", t, v, tbl[t].vec); end
      v = frame_obs(tbl[t].nbits, 4, 1'b1);
      n_cmp++;
      if (v !== tbl[t].vec) begin n_err++; $display("FAIL parity%0d_bits_last: got %h want %h", t, v, tbl[t].vec); end
      n_cmp++;
      if (fd_index(flen + 3) != flen) begin
        n_err++; $display("FAIL parity%0d_done_pos: got %0d want %0d", t, fd_index(flen + 3), flen);
      end
    end
    for (int i = 40; i < 48; i++) v[i-40] = cap_txd[i];
    n_cmp++;
    if (v[7:0] !== 8'hFF) begin n_err++; $display("FAIL two_stop_high: got %b want 11111111", v[7:0]); end
    parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;
  endtask

  task automatic test_back_to_back();
    int base, pops_seen, fds, low_cnt, d0, d1;
    base = pop_times.size();
    pops_seen = 0; fds = 0; low_cnt = 0;
    @(negedge clk);
    baud_div = 16'd3; parity_en = 0; two_stop = 0;
    push(16'h0011); push(16'h0022); push(16'h0033);
    tx_enable = 1'b1;
    #1;
    for (int i = 0; i < 300 && fds < 3; i++) begin
      if (i > 0) @(negedge clk);
      if (fifo_rd_en === 1'b1) pops_seen++;
      if (pops_seen >= 1 && tx_busy === 1'b0) low_cnt++;
      if (frame_done === 1'b1) fds++;
    end
    n_cmp++;
    if (fds != 3) begin n_err++; $display("FAIL b2b_frames: got %0d want 3", fds); end
    n_cmp++;
    if (low_cnt != 4) begin n_err++; $display("FAIL b2b_busy_low: got %0d cycles want 4", low_cnt); end
    repeat (60) @(negedge clk);
    tx_enable = 1'b0;
    n_cmp++;
    if (pop_times.size() - base != 3) begin
      n_err++; $display("FAIL b2b_pops: got %0d want 3", pop_times.size() - base);
    end else begin
      d0 = pop_times[base+1] - pop_times[base];
      d1 = pop_times[base+2] - pop_times[base+1];
      n_cmp++;
      if (d0 != 42) begin n_err++; $display("FAIL b2b_spacing0: got %0d want 42", d0); end
      n_cmp++;
      if (d1 != 42) begin n_err++; $display("FAIL b2b_spacing1: got %0d want 42", d1); end
    end
    n_cmp++;
    if (bad_pop != 0) begin n_err++; $display("FAIL pop_while_empty: got %0d want 0", bad_pop); end
  endtask

  task automatic test_midframe();
    int base;
    bit ok;
    logic [11:0] v;
    base = pop_times.size();
    @(negedge clk);
    baud_div = 16'd3; parity_en = 0; two_stop = 0;
    push(16'h003C); push(16'h0081);
    tx_enable = 1'b1;
    wait_start(20, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL mid_start: no start bit seen"); end
    for (int i = 0; i < 43; i++) begin
      if (i > 0) @(negedge clk);
      cap_txd[i] = txd;
      cap_fd[i]  = frame_done;
      if (i == 12) begin baud_div = 16'd0; parity_en = 1'b1; tx_enable = 1'b0; end
    end
    v = frame_obs(10, 4, 1'b0);
    n_cmp++;
    if (v !== 12'h278) begin n_err++; $display("FAIL mid_bits_first: got %h want 278", v); end
    v = frame_obs(10, 4, 1'b1);
    n_cmp++;
    if (v !== 12'h278) begin n_err++; $display("FAIL mid_bits_last: got %h want 278", v); end
    n_cmp++;
    if (fd_index(43) != 40) begin n_err++; $display("FAIL mid_done_pos: got %0d want 40", fd_index(43)); end
    repeat (20) @(negedge clk);
    n_cmp++;
    if (pop_times.size() - base != 1) begin
      n_err++; $display("FAIL mid_no_pop: got %0d pops want 1", pop_times.size() - base);
    end
  endtask

  task automatic test_div0();
    bit ok;
    logic [11:0] v;
    @(negedge clk);
    baud_div = 16'd0; parity_en = 0; two_stop = 0;
    tx_enable = 1'b1;
    wait_start(20, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL div0_start: no start bit seen"); end
    capture(13);
    tx_enable = 1'b0;
    v = frame_obs(10, 1, 1'b0);
    n_cmp++;
    if (v !== 12'h302) begin n_err++; $display("FAIL div0_bits: got %h want 302", v); end
    n_cmp++;
    if (fd_index(13) != 10) begin n_err++; $display("FAIL div0_done_pos: got %0d want 10", fd_index(13)); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int base;
    logic pre_txd;
    logic [11:0] v;
    @(negedge clk);
    baud_div = 16'd3; parity_en = 0; two_stop = 0;
    push(16'h00F0); push(16'h005A);
    tx_enable = 1'b1;
    wait_start(20, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL rmid_start: no start bit seen"); end
    repeat (10) @(negedge clk);
    pre_txd = txd;
    n_cmp++;
    if (pre_txd !== 1'b0) begin n_err++; $display("FAIL rmid_pre_txd: got %b want 0", pre_txd); end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({txd, tx_busy, fifo_rd_en} !== 3'b100) begin
      n_err++; $display("FAIL rmid_immediate: txd/busy/rd_en got %b want 100", {txd, tx_busy, fifo_rd_en});
    end
    base = pop_times.size();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (pop_times.size() != base) begin n_err++; $display("FAIL rmid_pop_in_reset: got %0d want 0", pop_times.size() - base); end
    rst_n = 1'b1;
    wait_start(20, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL rmid_restart: no start bit seen"); end
    capture(43);
    tx_enable = 1'b0;
    v = frame_obs(10, 4, 1'b0);
    n_cmp++;
    if (v !== 12'h2B4) begin n_err++; $display("FAIL rmid_bits_first: got %h want 2b4", v); end
    v = frame_obs(10, 4, 1'b1);
    n_cmp++;
    if (v !== 12'h2B4) begin n_err++; $display("FAIL rmid_bits_last: got %h want 2b4", v); end
    n_cmp++;
    if (fd_index(43) != 40) begin n_err++; $display("FAIL rmid_done_pos: got %0d want 40", fd_index(43)); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_back_to_back();
    test_midframe();
    test_div0();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
